// File: rtl/dwt_lifting_step.sv
// One streaming lifting step of the 9/7 or 5/3 row DWT: predict or update a sample pair per lane,
// with symmetric boundary extension, rounding, optional saturation and valid/ready flow control.
module dwt_lifting_step #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Point     = 10,
  parameter int unsigned CoefWidth = 18,
  parameter int          Coef      = -1624,
  parameter int unsigned Lanes     = 1,
  parameter string       Mode      = "Predict",
  parameter bit          Saturate  = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic                         s_ready_o,
  input  logic                         s_valid_i,
  input  logic                         s_sof_i,
  input  logic                         s_eol_i,
  input  logic [2*DataWidth*Lanes-1:0] s_data_i,
  input  logic                         m_ready_i,
  output logic                         m_valid_o,
  output logic                         m_sof_o,
  output logic                         m_eol_o,
  output logic [2*DataWidth*Lanes-1:0] m_data_o
);
  localparam int unsigned Pw = DataWidth + CoefWidth + 2;
  localparam int unsigned Bw = 2 * DataWidth * Lanes;

  localparam logic signed [CoefWidth-1:0] CoefC  = CoefWidth'(Coef);
  localparam logic signed [Pw-1:0]        CoefP  = Pw'(CoefC);
  localparam logic signed [Pw-1:0]        Half   = (Point == 0) ? '0 : (Pw'(1) << (Point - 1));
  localparam logic signed [Pw-1:0]        SatMax = {{(Pw-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
  localparam logic signed [Pw-1:0]        SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StHold, StFlush} state_e;

  // base + round_half_up(Coef * (a + b) / 2^Point), clamped or wrapped to DataWidth
  function automatic logic [DataWidth-1:0] lift(input logic [DataWidth-1:0] base,
                                                input logic [DataWidth-1:0] a,
                                                input logic [DataWidth-1:0] b);
    logic signed [Pw-1:0] t, p, r, res;
    t   = Pw'($signed(a)) + Pw'($signed(b));
    p   = t * CoefP;
    r   = (p + Half) >>> Point;
    res = Pw'($signed(base)) + r;
    if (Saturate && (res > SatMax)) begin
      res = SatMax;
    end else if (Saturate && (res < SatMin)) begin
      res = SatMin;
    end
    return res[DataWidth-1:0];
  endfunction

  logic ok;
  assign ok = !m_valid_o || m_ready_i;

  if (Mode == "Predict") begin : g_predict
    state_e        state_q;
    logic [Bw-1:0] hold_q;
    logic          hold_sof_q;
    logic [Bw-1:0] emit_data;
    logic          blocked;

    for (genvar k = 0; k < Lanes; k++) begin : g_lane
      localparam int unsigned Lo = 2 * DataWidth * k;
      logic [DataWidth-1:0] h_even, h_odd, next_even;
      assign h_even    = hold_q[Lo +: DataWidth];
      assign h_odd     = hold_q[Lo+DataWidth +: DataWidth];
      // in FLUSH the missing right neighbour mirrors onto the held even sample
      assign next_even = (state_q == StFlush) ? h_even : s_data_i[Lo +: DataWidth];
      assign emit_data[Lo +: 2*DataWidth] = {lift(h_odd, h_even, next_even), h_even};
    end

    // a new line arriving while a pair is held means the old line lost its eol
    assign blocked   = s_valid_i && s_sof_i;
    assign s_ready_o = ok && ((state_q == StIdle) || ((state_q == StHold) && !blocked));

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q    <= StIdle;
        hold_q     <= '0;
        hold_sof_q <= 1'b0;
        m_valid_o  <= 1'b0;
        m_sof_o    <= 1'b0;
        m_eol_o    <= 1'b0;
        m_data_o   <= '0;
      end else begin
        if (ok) m_valid_o <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (s_valid_i && s_ready_o) begin
              hold_q     <= s_data_i;
              hold_sof_q <= s_sof_i;
              state_q    <= s_eol_i ? StFlush : StHold;
            end
          end
          StHold: begin
            if (blocked) begin
              state_q <= StFlush;
            end else if (s_valid_i && ok) begin
              m_valid_o  <= 1'b1;
              m_data_o   <= emit_data;
              m_sof_o    <= hold_sof_q;
              m_eol_o    <= 1'b0;
              hold_q     <= s_data_i;
              hold_sof_q <= s_sof_i;
              if (s_eol_i) state_q <= StFlush;
            end
          end
          StFlush: begin
            if (ok) begin
              m_valid_o <= 1'b1;
              m_data_o  <= emit_data;
              m_sof_o   <= hold_sof_q;
              m_eol_o   <= 1'b1;
              state_q   <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end else if (Mode == "Update") begin : g_update
    logic [DataWidth*Lanes-1:0] d_prev_q, odd_all;
    logic [Bw-1:0]              emit_data;

    for (genvar k = 0; k < Lanes; k++) begin : g_lane
      localparam int unsigned Lo = 2 * DataWidth * k;
      logic [DataWidth-1:0] even, odd, prev;
      assign even = s_data_i[Lo +: DataWidth];
      assign odd  = s_data_i[Lo+DataWidth +: DataWidth];
      assign odd_all[k*DataWidth +: DataWidth] = odd;
      // at line start d[-1] mirrors onto d[1]
      assign prev = s_sof_i ? odd : d_prev_q[k*DataWidth +: DataWidth];
      assign emit_data[Lo +: 2*DataWidth] = {odd, lift(even, prev, odd)};
    end

    assign s_ready_o = ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        d_prev_q  <= '0;
        m_valid_o <= 1'b0;
        m_sof_o   <= 1'b0;
        m_eol_o   <= 1'b0;
        m_data_o  <= '0;
      end else if (ok) begin
        m_valid_o <= s_valid_i;
        if (s_valid_i) begin
          m_data_o <= emit_data;
          m_sof_o  <= s_sof_i;
          m_eol_o  <= s_eol_i;
          d_prev_q <= odd_all;
        end
      end
    end
  end else begin : g_bad_mode
    $fatal(1, "dwt_lifting_step: Mode must be \"Predict\" or \"Update\"");
  end

endmodule

// File: tb/tb_dwt_lifting_step.sv
// Directed bench for dwt_lifting_step: predict/update arithmetic, boundaries, rounding,
// saturation, missing eol, asynchronous reset and a randomised backpressure line.
module tb_dwt_lifting_step;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // predict, alpha = -0.5, two lanes
  logic        p_valid = 1'b0, p_sof = 1'b0, p_eol = 1'b0, p_mready = 1'b1;
  logic [63:0] p_data = '0;
  logic        p_sready, p_mvalid, p_msof, p_meol;
  logic [63:0] p_mdata;

  // update, coefficient 0.25
  logic        u_valid = 1'b0, u_sof = 1'b0, u_eol = 1'b0, u_mready = 1'b1;
  logic [31:0] u_data = '0;
  logic        u_sready, u_mvalid, u_msof, u_meol;
  logic [31:0] u_mdata;

  // shared-input single-lane predict instances: saturate, wrap, rounding
  logic        a_valid = 1'b0, a_sof = 1'b0, a_eol = 1'b0;
  logic [31:0] a_data = '0;
  logic        s_sready, s_mvalid, s_msof, s_meol;
  logic [31:0] s_mdata;
  logic        w_sready, w_mvalid, w_msof, w_meol;
  logic [31:0] w_mdata;
  logic        r_sready, r_mvalid, r_msof, r_meol;
  logic [31:0] r_mdata;

  dwt_lifting_step #(.Coef(-512), .Lanes(2), .Mode("Predict"), .Saturate(1'b1)) u_pred (
    .clk_i(clk), .rst_i(rst), .s_ready_o(p_sready), .s_valid_i(p_valid), .s_sof_i(p_sof),
    .s_eol_i(p_eol), .s_data_i(p_data), .m_ready_i(p_mready), .m_valid_o(p_mvalid),
    .m_sof_o(p_msof), .m_eol_o(p_meol), .m_data_o(p_mdata));

  dwt_lifting_step #(.Coef(256), .Lanes(1), .Mode("Update"), .Saturate(1'b1)) u_upd (
    .clk_i(clk), .rst_i(rst), .s_ready_o(u_sready), .s_valid_i(u_valid), .s_sof_i(u_sof),
    .s_eol_i(u_eol), .s_data_i(u_data), .m_ready_i(u_mready), .m_valid_o(u_mvalid),
    .m_sof_o(u_msof), .m_eol_o(u_meol), .m_data_o(u_mdata));

  dwt_lifting_step #(.Coef(1024), .Lanes(1), .Mode("Predict"), .Saturate(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst), .s_ready_o(s_sready), .s_valid_i(a_valid), .s_sof_i(a_sof),
    .s_eol_i(a_eol), .s_data_i(a_data), .m_ready_i(1'b1), .m_valid_o(s_mvalid),
    .m_sof_o(s_msof), .m_eol_o(s_meol), .m_data_o(s_mdata));

  dwt_lifting_step #(.Coef(1024), .Lanes(1), .Mode("Predict"), .Saturate(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .s_ready_o(w_sready), .s_valid_i(a_valid), .s_sof_i(a_sof),
    .s_eol_i(a_eol), .s_data_i(a_data), .m_ready_i(1'b1), .m_valid_o(w_mvalid),
    .m_sof_o(w_msof), .m_eol_o(w_meol), .m_data_o(w_mdata));

  dwt_lifting_step #(.Coef(512), .Lanes(1), .Mode("Predict"), .Saturate(1'b1)) u_rnd (
    .clk_i(clk), .rst_i(rst), .s_ready_o(r_sready), .s_valid_i(a_valid), .s_sof_i(a_sof),
    .s_eol_i(a_eol), .s_data_i(a_data), .m_ready_i(1'b1), .m_valid_o(r_mvalid),
    .m_sof_o(r_msof), .m_eol_o(r_meol), .m_data_o(r_mdata));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pr(input int odd, input int even);
    return {16'(odd), 16'(even)};
  endfunction

  function automatic logic [63:0] pp(input int odd, input int even);
    return {pr(odd, even), pr(odd, even)};
  endfunction

  // golden predict step for alpha = -512 / 2^10
  function automatic int pred_ref(input int odd, input int e0, input int e1);
    int r, v;
    r = ((e0 + e1) * -512 + 512) >>> 10;
    v = odd + r;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic p_drive(input logic v, input logic sof, input logic eol, input logic [63:0] d);
    p_valid = v; p_sof = sof; p_eol = eol; p_data = d;
  endtask

  task automatic u_drive(input logic v, input logic sof, input logic eol, input logic [31:0] d);
    u_valid = v; u_sof = sof; u_eol = eol; u_data = d;
  endtask

  task automatic a_drive(input logic v, input logic sof, input logic eol, input logic [31:0] d);
    a_valid = v; a_sof = sof; a_eol = eol; a_data = d;
  endtask

  // two-pair line through the predict instance with an always-ready sink
  task automatic p_basic_line(input string tag);
    @(negedge clk);
    p_drive(1'b1, 1'b1, 1'b0, {pr(-20, -10), pr(20, 10)});
    #1 check({tag, "_rdy_idle"}, 128'(p_sready), 128'(1'b1));
    @(negedge clk);
    check({tag, "_no_out_yet"}, 128'(p_mvalid), 128'(1'b0));
    p_drive(1'b1, 1'b0, 1'b1, {pr(-40, -30), pr(40, 30)});
    #1 check({tag, "_rdy_hold"}, 128'(p_sready), 128'(1'b1));
    @(negedge clk);
    check({tag, "_out0"}, 128'({p_mvalid, p_msof, p_meol, p_mdata}),
          128'({1'b1, 1'b1, 1'b0, pr(0, -10), pr(0, 10)}));
    p_drive(1'b0, 1'b0, 1'b0, '0);
    #1 check({tag, "_rdy_flush"}, 128'(p_sready), 128'(1'b0));
    @(negedge clk);
    check({tag, "_out1"}, 128'({p_mvalid, p_msof, p_meol, p_mdata}),
          128'({1'b1, 1'b0, 1'b1, pr(-10, -30), pr(10, 30)}));
    #1 check({tag, "_rdy_back"}, 128'(p_sready), 128'(1'b1));
    @(negedge clk);
    check({tag, "_drained"}, 128'(p_mvalid), 128'(1'b0));
  endtask

  int xo [2][64];
  int xe [2][64];
  logic [63:0] exp_q [64];
  logic [127:0] held;
  logic stall;
  int in_i, out_i;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pred", 128'({p_mvalid, p_msof, p_meol, p_mdata}), 128'(0));
    check("reset_upd", 128'({u_mvalid, u_msof, u_meol, u_mdata}), 128'(0));
    rst = 1'b0;

    p_basic_line("pred");

    // update: even += 0.25 * (d_prev + d), d[-1] mirrored from d[1]
    @(negedge clk);
    u_drive(1'b1, 1'b1, 1'b0, pr(4, 10));
    #1 check("upd_rdy", 128'(u_sready), 128'(1'b1));
    @(negedge clk);
    check("upd_out0", 128'({u_mvalid, u_msof, u_meol, u_mdata}), 128'({3'b110, pr(4, 12)}));
    u_drive(1'b1, 1'b0, 1'b1, pr(8, 20));
    @(negedge clk);
    check("upd_out1", 128'({u_mvalid, u_msof, u_meol, u_mdata}), 128'({3'b101, pr(8, 23)}));
    u_drive(1'b0, 1'b0, 1'b0, '0);
    u_mready = 1'b0;
    #1 check("upd_rdy_stall", 128'(u_sready), 128'(1'b0));
    @(negedge clk);
    check("upd_stall_hold", 128'({u_mvalid, u_msof, u_meol, u_mdata}), 128'({3'b101, pr(8, 23)}));
    u_mready = 1'b1;
    #1 check("upd_rdy_release", 128'(u_sready), 128'(1'b1));
    @(negedge clk);
    check("upd_drained", 128'(u_mvalid), 128'(1'b0));

    // saturation vs wrap: 32000 + 1.0 * (1000 + 1000)
    a_drive(1'b1, 1'b1, 1'b1, pr(32000, 1000));
    @(negedge clk);
    a_drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("sat_clamp", 128'({s_mvalid, s_msof, s_meol, s_mdata}), 128'({3'b111, pr(32767, 1000)}));
    check("sat_wrap", 128'({w_mvalid, w_msof, w_meol, w_mdata}), 128'({3'b111, pr(-31536, 1000)}));

    // rounding with coefficient 0.5: t=3 -> 2, t=4 -> 2, t=-3 -> -1, t=-4 -> -2
    @(negedge clk);
    a_drive(1'b1, 1'b1, 1'b0, pr(0, 1));
    @(negedge clk);
    a_drive(1'b1, 1'b0, 1'b1, pr(0, 2));
    @(negedge clk);
    check("rnd_pos3", 128'({r_mvalid, r_msof, r_meol, r_mdata}), 128'({3'b110, pr(2, 1)}));
    a_drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("rnd_pos4", 128'({r_mvalid, r_msof, r_meol, r_mdata}), 128'({3'b101, pr(2, 2)}));
    @(negedge clk);
    a_drive(1'b1, 1'b1, 1'b0, pr(0, -1));
    @(negedge clk);
    a_drive(1'b1, 1'b0, 1'b1, pr(0, -2));
    @(negedge clk);
    check("rnd_neg3", 128'({r_mvalid, r_msof, r_meol, r_mdata}), 128'({3'b110, pr(-1, -1)}));
    a_drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("rnd_neg4", 128'({r_mvalid, r_msof, r_meol, r_mdata}), 128'({3'b101, pr(-2, -2)}));

    // missing eol: sof arrives while a pair is held
    @(negedge clk);
    p_drive(1'b1, 1'b1, 1'b0, pp(2, 4));
    @(negedge clk);
    p_drive(1'b1, 1'b0, 1'b0, pp(6, 8));
    @(negedge clk);
    check("noeol_out0", 128'({p_mvalid, p_msof, p_meol, p_mdata}), 128'({3'b110, pp(-4, 4)}));
    p_drive(1'b1, 1'b1, 1'b1, pp(100, 50));
    #1 check("noeol_rdy_blocked", 128'(p_sready), 128'(1'b0));
    @(negedge clk);
    check("noeol_gap", 128'(p_mvalid), 128'(1'b0));
    #1 check("noeol_rdy_flush", 128'(p_sready), 128'(1'b0));
    @(negedge clk);
    check("noeol_mirror", 128'({p_mvalid, p_msof, p_meol, p_mdata}), 128'({3'b101, pp(-2, 8)}));
    #1 check("noeol_rdy_new", 128'(p_sready), 128'(1'b1));
    @(negedge clk);
    check("noeol_gap2", 128'(p_mvalid), 128'(1'b0));
    p_drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("noeol_newline", 128'({p_mvalid, p_msof, p_meol, p_mdata}), 128'({3'b111, pp(50, 50)}));

    // asynchronous reset in the middle of a line with a stalled output
    @(negedge clk);
    p_drive(1'b1, 1'b1, 1'b0, pp(2, 4));
    @(negedge clk);
    p_drive(1'b1, 1'b0, 1'b0, pp(6, 8));
    p_mready = 1'b0;
    @(negedge clk);
    p_drive(1'b0, 1'b0, 1'b0, '0);
    check("midrst_pending", 128'(p_mvalid), 128'(1'b1));
    #2 rst = 1'b1;
    #1 check("midrst_async", 128'({p_mvalid, p_msof, p_meol, p_mdata}), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    p_mready = 1'b1;
    p_basic_line("after_rst");

    // 64-pair two-lane line with random source and sink stalls
    for (int n = 0; n < 64; n++) begin
      for (int l = 0; l < 2; l++) begin
        xo[l][n] = int'($urandom_range(4000)) - 2000;
        xe[l][n] = int'($urandom_range(4000)) - 2000;
      end
    end
    for (int n = 0; n < 64; n++) begin
      for (int l = 0; l < 2; l++) begin
        exp_q[n][l*32 +: 32] = pr(pred_ref(xo[l][n], xe[l][n], xe[l][(n == 63) ? n : n + 1]),
                                  xe[l][n]);
      end
    end
    in_i = 0;
    out_i = 0;
    stall = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 3000 && out_i < 64; cyc++) begin
      @(negedge clk);
      if (stall) check("bp_stable", 128'({p_mvalid, p_msof, p_meol, p_mdata}), held);
      p_mready = ($urandom_range(3) != 0);
      if (p_mvalid && p_mready) begin
        check("bp_out", 128'({p_msof, p_meol, p_mdata}),
              128'({out_i == 0, out_i == 63, exp_q[out_i]}));
        out_i++;
      end
      stall = p_mvalid && !p_mready;
      held = 128'({p_mvalid, p_msof, p_meol, p_mdata});
      if (in_i < 64 && $urandom_range(3) != 0)
        p_drive(1'b1, in_i == 0, in_i == 63,
                {pr(xo[1][in_i], xe[1][in_i]), pr(xo[0][in_i], xe[0][in_i])});
      else
        p_drive(1'b0, 1'b0, 1'b0, '0);
      #1;
      if (p_valid && p_sready) in_i++;
    end
    check("bp_in_count", 128'(in_i), 128'(64));
    check("bp_out_count", 128'(out_i), 128'(64));
    p_drive(1'b0, 1'b0, 1'b0, '0);
    p_mready = 1'b1;
    @(negedge clk);
    check("bp_no_extra", 128'(p_mvalid), 128'(1'b0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dwt_lifting_step.md
Name: dwt_lifting_step

Overview:
- Streaming, parametrised single lifting step of the DWT 9/7 (or 5/3) row filter; successor to the fixed two-step processing unit.
- Processes one {odd, even} sample pair per lane per cycle. Mode selects a predict step (odd updated from neighbouring evens) or an update step (even updated from neighbouring odds).
- Adds symmetric boundary extension at line start and end, full valid/ready backpressure, N parallel lanes, rounding and optional saturation.
- Four instances chained (alpha, beta, gamma, delta) plus scaling form a complete row transform.

Parameters:
- DataWidth, 16, signed sample width per odd/even word.
- Point, 10, fractional bits of Coef.
- Coef, -1624, signed lifting coefficient, value Coef/2^Point (default is alpha).
- CoefWidth, 18, signed width of Coef.
- Lanes, 1, independent channels sharing one handshake.
- Mode, "Predict", "Predict" or "Update". Any other value fails elaboration.
- Saturate, 1, 1 = clamp result to DataWidth range; 0 = two's-complement wrap.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- s_ready_o  out  1  input ready.
- s_valid_i  in  1  input valid.
- s_sof_i  in  1  first pair of a line.
- s_eol_i  in  1  last pair of a line.
- s_data_i  in  2*DataWidth*Lanes  lane k at bits [2*DataWidth*(k+1)-1 : 2*DataWidth*k], {odd, even}.
- m_ready_i  in  1  output ready.
- m_valid_o  out  1  output valid.
- m_sof_o  out  1  first output pair of a line.
- m_eol_o  out  1  last output pair of a line.
- m_data_o  out  2*DataWidth*Lanes  same packing; the non-updated word passes through unchanged.

Behaviour:
- Handshake: a beat transfers when valid and ready are both high.
- Output register: m_valid_o holds until m_ready_i. While m_valid_o is high, data/sof/eol are stable.
- Output register ready: ok = !m_valid_o | m_ready_i.
- Reset: m_valid_o, m_sof_o, m_eol_o = 0; m_data_o = 0; FSM goes to IDLE; hold registers are cleared. Reset mid-line discards all partial state with no output. The first beat after reset must carry sof.
- Arithmetic, per lane: t = a + b in DataWidth+1 bits; p = t*Coef (full width); r = (p + 2^(Point-1)) >>> Point (round half-up); res = base + r.
  - Saturate=1: res clamps to [-2^(DataWidth-1), 2^(DataWidth-1)-1].
  - Saturate=0: res is truncated to DataWidth bits.
- Update mode (stateless FSM):
  - Pair n = {d[2n+1], x[2n]}. Output even = x[2n] + C*(d_prev + d[2n+1]); output odd = d[2n+1].
  - d_prev = odd of the previous accepted pair. On sof, d_prev = d[2n+1] (mirror d[-1] = d[1]).
  - s_ready_o = ok. Latency 1 cycle. sof/eol forwarded with the pair. Full throughput.
- Predict mode, FSM IDLE / HOLD / FLUSH, hold register H (one pair per lane plus sof flag):
  - Pair n = {x[2n+1], x[2n]}. Output odd = x[2n+1] + C*(x[2n] + x[2n+2]); output even = x[2n].
  - IDLE: s_ready_o = ok.
    - Accept without eol: store H, go to HOLD.
    - Accept with sof & eol: store H, go to FLUSH.
  - HOLD: s_ready_o = ok & !(s_valid_i & s_sof_i).
    - Accept: emit H using the incoming even as x[2n+2], with m_sof_o = H.sof and m_eol_o = 0. The incoming beat becomes H.
    - If the incoming beat has eol, go to FLUSH; else stay in HOLD.
  - HOLD with s_valid_i & s_sof_i (eol missing on the previous line): go to FLUSH without accepting. The sof beat is accepted after the flush.
  - FLUSH: s_ready_o = 0. When ok, emit H with mirror x[2n+2] = x[2n] and m_eol_o = 1, then go to IDLE.
  - Latency: pair n appears 1 cycle after pair n+1 is accepted, or 1 cycle after entering FLUSH.
  - Throughput: one bubble per line (the flush cycle).
- Lanes: lanes compute independently; sof/eol/valid are shared.
- Simultaneous m_ready_i and a new result: the output register reloads in the same cycle with no bubble.

Test Plan:
- Predict, Coef=-512, Point=10: pairs {20,10}sof, {40,30}eol -> outputs {0,10}sof, then {10,30}eol. s_ready_o is low for 1 cycle during FLUSH.
- Update, Coef=256: pairs {4,10}sof, {8,20}eol -> outputs {4,12}sof, then {8,23}eol, each 1 cycle after its input.
- Saturation, Predict, Coef=1024, single pair {32000,1000} with sof&eol -> odd = 32767 (Saturate=1) or -31536 (Saturate=0).
- Rounding, Coef=512, sum t=3 -> r=2; t=-3 -> r=-1.
- Backpressure: Lanes=2, 64-pair line, random m_ready_i and s_valid_i -> no loss or duplication, output stable while stalled, every lane matches the golden model, one sof and one eol per line.
- Missing eol: sof arrives in HOLD -> held pair is emitted mirrored with eol=1, then the new line proceeds. Async reset mid-line -> m_valid_o=0 immediately and the next line output is correct.
